// File: rtl/iter_div32.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Define ITER_DIV_EARLY_OUT_EN to finish divide-by-zero and overflow in two cycles.
module iter_div32 #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [4:0]        op_sel,
   input  logic [DATA_W-1:0] rs1,
   input  logic [DATA_W-1:0] rs2,
   input  logic              flush,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX
   } state_t;

   state_t            r_state;
   logic [4:0]        r_cnt;
   logic [DATA_W-1:0] r_rem;
   logic [DATA_W-1:0] r_quo;
   logic [DATA_W-1:0] r_dvs;
   logic              r_neg_q;
   logic              r_neg_r;
   logic              r_want_rem;
   logic              r_done;
   logic [DATA_W-1:0] r_result;

   logic              w_valid_op;
   logic              w_signed;
   logic [DATA_W-1:0] w_abs1;
   logic [DATA_W-1:0] w_abs2;
   logic [DATA_W:0]   w_sh;
   logic              w_ge;
   logic [DATA_W-1:0] w_diff;
   logic [DATA_W-1:0] w_q_fix;
   logic [DATA_W-1:0] w_r_fix;
   logic              w_early;

   assign w_valid_op = (op_sel[4:2] == 3'b101);
   assign w_signed   = ~op_sel[0];
   assign w_abs1     = (w_signed & rs1[DATA_W-1]) ? -rs1 : rs1;
   assign w_abs2     = (w_signed & rs2[DATA_W-1]) ? -rs2 : rs2;

   // Trial subtract on the 33-bit shifted remainder; low bits suffice when it fits.
   assign w_sh   = {r_rem, r_quo[DATA_W-1]};
   assign w_ge   = (w_sh >= {1'b0, r_dvs});
   assign w_diff = w_sh[DATA_W-1:0] - r_dvs;

   assign w_q_fix = r_neg_q ? -r_quo : r_quo;
   assign w_r_fix = r_neg_r ? -r_rem : r_rem;

`ifdef ITER_DIV_EARLY_OUT_EN
   assign w_early = (rs2 == '0) |
                    (w_signed & (rs1 == {1'b1, {(DATA_W-1){1'b0}}}) &
                     (rs2 == '1));
`else
   assign w_early = 1'b0;
`endif

   assign busy   = (r_state != S_IDLE);
   assign done   = r_done;
   assign result = r_result;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_rem      <= '0;
         r_quo      <= '0;
         r_dvs      <= '0;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_want_rem <= 1'b0;
         r_done     <= 1'b0;
         r_result   <= '0;
      end else begin
         r_done <= 1'b0;
         if (flush) begin
            r_state <= S_IDLE;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  if (start && w_valid_op) begin
                     r_dvs      <= w_abs2;
                     r_neg_q    <= w_signed & (rs1[DATA_W-1] ^ rs2[DATA_W-1]) &
                                   (rs2 != '0);
                     r_neg_r    <= w_signed & rs1[DATA_W-1];
                     r_want_rem <= op_sel[1];
                     r_cnt      <= '0;
                     if (w_early) begin
                        // Preload what the full iteration would have produced.
                        r_quo   <= (rs2 == '0) ? '1 : w_abs1;
                        r_rem   <= (rs2 == '0) ? w_abs1 : '0;
                        r_state <= S_FIX;
                     end else begin
                        r_quo   <= w_abs1;
                        r_rem   <= '0;
                        r_state <= S_RUN;
                     end
                  end
               end
               S_RUN: begin
                  r_rem <= w_ge ? w_diff : w_sh[DATA_W-1:0];
                  r_quo <= {r_quo[DATA_W-2:0], w_ge};
                  r_cnt <= r_cnt + 5'd1;
                  if (r_cnt == 5'd31) begin
                     r_state <= S_FIX;
                  end
               end
               S_FIX: begin
                  r_result <= r_want_rem ? w_r_fix : w_q_fix;
                  r_done   <= 1'b1;
                  r_state  <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
